// File: rtl/lcd_timing_ctrl.sv
// 800x480 RGB LCD timing generator and backlight power sequencer.
// Latency: pix_x/pix_y lead lcd_de by one clock; lcd_rgb is combinational from pix_data_in and lcd_de.
// Backpressure: none; free-running pixel clock. Optional TEST_PATTERN_EN adds test_sel (grey ramp).
module lcd_timing_ctrl #(
    parameter int H_SYNC    = 128,
    parameter int H_BACK    = 88,
    parameter int H_VALID   = 800,
    parameter int H_FRONT   = 40,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int V_VALID   = 480,
    parameter int V_FRONT   = 10,
    parameter int BL_FRAMES = 2
) (
    input  logic        clk_in,
    input  logic        sys_rst_n,
    input  logic        enable,
    input  logic [23:0] pix_data_in,
`ifdef TEST_PATTERN_EN
    input  logic        test_sel,
`endif
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        lcd_hs,
    output logic        lcd_vs,
    output logic        lcd_de,
    output logic [23:0] lcd_rgb,
    output logic        lcd_bl,
    output logic        frame_start
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int HS0     = H_SYNC + H_BACK;
    localparam int VS0     = V_SYNC + V_BACK;

    // Counter compare points, sized to the counters
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ONE      = HW'(1);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
    localparam logic [HW-1:0] H_DE_BEG   = HW'(HS0);
    localparam logic [HW-1:0] H_DE_END   = HW'(HS0 + H_VALID);
    // Requests lead DE by one column to cover the generator's register stage
    localparam logic [HW-1:0] H_RQ_BEG   = HW'(HS0 - 1);
    localparam logic [HW-1:0] H_RQ_LAST  = HW'(HS0 + H_VALID - 2);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ONE      = VW'(1);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_BEG  = VW'(VS0);
    localparam logic [VW-1:0] V_ACT_END  = VW'(VS0 + V_VALID);
    localparam logic [3:0]    BL_LAST    = 4'(BL_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_DARK  = 2'd1,
        ST_ON    = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // All panel-side timing outputs travel together so they stay aligned
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic       fs;
        logic [9:0] px;
        logic [9:0] py;
    } tmg_t;

    localparam tmg_t TMG_IDLE = '{hs: 1'b0, vs: 1'b0, de: 1'b0, fs: 1'b0,
                                  px: 10'h3FF, py: 10'h3FF};

    state_t        r_state;
    logic [3:0]    r_bl_cnt;
    logic          r_bl;
    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    tmg_t          r_tmg;
    tmg_t          w_tmg;
    logic          w_run;
    logic          w_h_last;
    logic          w_v_last;
    logic          w_frame_wrap;
    logic          w_act_row;
    logic          w_req_col;
    logic          w_de_col;
    logic [23:0]   w_rgb_src;

    assign w_run        = (r_state != ST_OFF);
    assign w_h_last     = (r_h_cnt == H_LAST);
    assign w_v_last     = (r_v_cnt == V_LAST);
    assign w_frame_wrap = w_run && w_h_last && w_v_last;
    assign w_act_row    = (r_v_cnt >= V_ACT_BEG) && (r_v_cnt < V_ACT_END);
    assign w_req_col    = (r_h_cnt >= H_RQ_BEG) && (r_h_cnt <= H_RQ_LAST);
    assign w_de_col     = (r_h_cnt >= H_DE_BEG) && (r_h_cnt < H_DE_END);

    // Power sequencer: OFF -> DARK (BL_FRAMES dark frames) -> ON; disable drains to frame end
    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state  <= ST_OFF;
            r_bl_cnt <= 4'd0;
            r_bl     <= 1'b0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    r_bl     <= 1'b0;
                    r_bl_cnt <= 4'd0;
                    if (enable) begin
                        r_state <= ST_DARK;
                    end
                end
                ST_DARK: begin
                    if (!enable) begin
                        r_state <= ST_DRAIN;
                        r_bl    <= 1'b0;
                    end else if (w_frame_wrap) begin
                        if (r_bl_cnt == BL_LAST) begin
                            r_state <= ST_ON;
                            r_bl    <= 1'b1;
                        end else begin
                            r_bl_cnt <= r_bl_cnt + 4'd1;
                        end
                    end
                end
                ST_ON: begin
                    if (!enable) begin
                        r_state <= ST_DRAIN;
                        r_bl    <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // enable is deliberately ignored until the frame finishes
                    r_bl <= 1'b0;
                    if (w_frame_wrap) begin
                        r_state <= ST_OFF;
                    end
                end
                default: begin
                    r_state <= ST_OFF;
                    r_bl    <= 1'b0;
                end
            endcase
        end
    end

    // Raster counters: run whenever the panel is sequenced up, parked at 0 in OFF
    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (!w_run) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : (r_v_cnt + V_ONE);
        end else begin
            r_h_cnt <= r_h_cnt + H_ONE;
        end
    end

    // Decode sync, DE, frame marker and pixel request from the current raster position
    always_comb begin
        w_tmg = TMG_IDLE;
        if (w_run) begin
            w_tmg.hs = (r_h_cnt < H_SYNC_END);
            w_tmg.vs = (r_v_cnt < V_SYNC_END);
            w_tmg.de = w_act_row && w_de_col;
            w_tmg.fs = (r_h_cnt == '0) && (r_v_cnt == '0);
            if (w_act_row && w_req_col) begin
                w_tmg.px = 10'(r_h_cnt - H_RQ_BEG);
                w_tmg.py = 10'(r_v_cnt - V_ACT_BEG);
            end
        end
    end

    // Register the whole timing bundle in one stage so every output shares the same delay
    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_tmg <= TMG_IDLE;
        end else begin
            r_tmg <= w_tmg;
        end
    end

`ifdef TEST_PATTERN_EN
    logic [7:0] r_de_x;

    // Column index of the DE beat, registered alongside DE for the grey ramp
    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_de_x <= 8'd0;
        end else if (!w_run) begin
            r_de_x <= 8'd0;
        end else begin
            r_de_x <= 8'(r_h_cnt - H_DE_BEG);
        end
    end

    assign w_rgb_src = test_sel ? {3{r_de_x}} : pix_data_in;
`else
    assign w_rgb_src = pix_data_in;
`endif

    assign pix_x       = r_tmg.px;
    assign pix_y       = r_tmg.py;
    assign lcd_hs      = r_tmg.hs;
    assign lcd_vs      = r_tmg.vs;
    assign lcd_de      = r_tmg.de;
    assign frame_start = r_tmg.fs;
    assign lcd_bl      = r_bl;
    // Blank the bus outside DE so porch data from the generator never reaches the panel
    assign lcd_rgb     = r_tmg.de ? w_rgb_src : 24'h0;

endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// Bench for lcd_timing_ctrl using a reduced raster (17 x 9 clocks) so whole frames fit in a short run.
// Generator model returns {pix_x, pix_y, 4'h0} one clock after the request.
// Directed vectors per frame offset plus hand-written power-sequencing and reset sequences.
module tb_lcd_timing_ctrl;

    localparam int HT = 17;
    localparam int VT = 9;
    localparam int FT = HT * VT;

    logic        clk_in = 1'b0;
    logic        sys_rst_n;
    logic        enable;
    logic [23:0] pix_data_in = 24'h0;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        lcd_hs;
    logic        lcd_vs;
    logic        lcd_de;
    logic [23:0] lcd_rgb;
    logic        lcd_bl;
    logic        frame_start;
`ifdef TEST_PATTERN_EN
    logic        test_sel = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    lcd_timing_ctrl #(
        .H_SYNC(4), .H_BACK(3), .H_VALID(8), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(2), .V_VALID(4), .V_FRONT(1),
        .BL_FRAMES(2)
    ) dut (
        .clk_in      (clk_in),
        .sys_rst_n   (sys_rst_n),
        .enable      (enable),
        .pix_data_in (pix_data_in),
`ifdef TEST_PATTERN_EN
        .test_sel    (test_sel),
`endif
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .lcd_hs      (lcd_hs),
        .lcd_vs      (lcd_vs),
        .lcd_de      (lcd_de),
        .lcd_rgb     (lcd_rgb),
        .lcd_bl      (lcd_bl),
        .frame_start (frame_start)
    );

    always #5 clk_in = ~clk_in;

    // Registered pixel generator: one clock from request to data
    always @(posedge clk_in) pix_data_in <= {pix_x, pix_y, 4'h0};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic wait_fs(output int lat);
        lat = -1;
        for (int i = 1; i <= 2 * FT + 4; i++) begin
            @(negedge clk_in);
            if (frame_start) begin
                lat = i;
                break;
            end
        end
    endtask

    // DE scoreboard: every beat must carry its own coordinate, blank outside DE
    int  m_col = 0;
    int  m_row = 0;
    bit  m_prev_de = 1'b0;
    bit  m_seen_fs = 1'b0;
    always @(negedge clk_in) begin
        if (mon_en) begin
            if (frame_start) begin
                if (m_seen_fs) chk("de_lines_per_frame", m_row, 4);
                m_seen_fs = 1'b1;
                m_row = 0;
            end
            if (lcd_de) begin
                chk($sformatf("rgb_c%0d_r%0d", m_col, m_row), lcd_rgb,
                    {m_col[9:0], m_row[9:0], 4'h0});
                m_col++;
            end else begin
                chk("rgb_blank", lcd_rgb, 24'h0);
                if (m_prev_de) begin
                    chk("de_per_line", m_col, 8);
                    m_row++;
                    m_col = 0;
                end
            end
            m_prev_de = lcd_de;
        end
    end

    typedef struct {
        int          s;
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic [9:0]  px;
        logic [9:0]  py;
        logic [23:0] rgb;
    } vec_t;

    vec_t vt[14];

    initial begin
        int lat;
        int vi;
        int hs_cnt;
        int de_cnt;
        int bl_rise;
        int fs_pos[$];
        int fs_at;

        // Offsets from frame_start; raster h = s % 17, v = s / 17
        vt[0]  = '{0,   1'b1, 1'b1, 1'b0, 1'b1, 10'h3FF, 10'h3FF, 24'h0};
        vt[1]  = '{3,   1'b1, 1'b1, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 24'h0};
        vt[2]  = '{4,   1'b0, 1'b1, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 24'h0};
        vt[3]  = '{33,  1'b0, 1'b1, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 24'h0};
        vt[4]  = '{34,  1'b1, 1'b0, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 24'h0};
        vt[5]  = '{73,  1'b0, 1'b0, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 24'h0};
        vt[6]  = '{74,  1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   10'd0,   24'h0};
        vt[7]  = '{75,  1'b0, 1'b0, 1'b1, 1'b0, 10'd1,   10'd0,   24'h0};
        vt[8]  = '{81,  1'b0, 1'b0, 1'b1, 1'b0, 10'd7,   10'd0,   24'h018000};
        vt[9]  = '{82,  1'b0, 1'b0, 1'b1, 1'b0, 10'h3FF, 10'h3FF, 24'h01C000};
        vt[10] = '{83,  1'b0, 1'b0, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 24'h0};
        vt[11] = '{132, 1'b0, 1'b0, 1'b1, 1'b0, 10'd7,   10'd3,   24'h018030};
        vt[12] = '{133, 1'b0, 1'b0, 1'b1, 1'b0, 10'h3FF, 10'h3FF, 24'h01C030};
        vt[13] = '{142, 1'b0, 1'b0, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 24'h0};

        // Reset values
        sys_rst_n = 1'b1;
        enable    = 1'b0;
        #1 sys_rst_n = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("rst_pix_x", pix_x, 10'h3FF);
        chk("rst_pix_y", pix_y, 10'h3FF);
        chk("rst_hs", lcd_hs, 0);
        chk("rst_vs", lcd_vs, 0);
        chk("rst_de", lcd_de, 0);
        chk("rst_bl", lcd_bl, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_rgb", lcd_rgb, 0);

        // Idle in OFF with enable low
        sys_rst_n = 1'b1;
        repeat (4) @(negedge clk_in);
        chk("off_idle_hs", lcd_hs, 0);
        chk("off_idle_fs", frame_start, 0);

        // Enable: DARK next clock, frame_start one clock after that
        enable = 1'b1;
        mon_en = 1'b1;
        wait_fs(lat);
        chk("enable_to_fs", lat, 2);

        // Three frames: vector table on the first, sequencing on all
        vi = 0; hs_cnt = 0; de_cnt = 0; bl_rise = -1;
        for (int s = 0; s < 3 * FT; s++) begin
            if (s > 0) @(negedge clk_in);
            if (vi < 14 && vt[vi].s == s) begin
                chk($sformatf("v%0d_hs", vi),  lcd_hs,      vt[vi].hs);
                chk($sformatf("v%0d_vs", vi),  lcd_vs,      vt[vi].vs);
                chk($sformatf("v%0d_de", vi),  lcd_de,      vt[vi].de);
                chk($sformatf("v%0d_fs", vi),  frame_start, vt[vi].fs);
                chk($sformatf("v%0d_px", vi),  pix_x,       vt[vi].px);
                chk($sformatf("v%0d_py", vi),  pix_y,       vt[vi].py);
                chk($sformatf("v%0d_rgb", vi), lcd_rgb,     vt[vi].rgb);
                vi++;
            end
            if (s < FT) begin
                hs_cnt += int'(lcd_hs);
                de_cnt += int'(lcd_de);
            end
            if (frame_start) fs_pos.push_back(s);
            if (lcd_bl && bl_rise < 0) bl_rise = s;
        end
        chk("hs_clocks_per_frame", hs_cnt, 36);
        chk("de_clocks_per_frame", de_cnt, 32);
        chk("fs_count", fs_pos.size(), 3);
        if (fs_pos.size() == 3) begin
            chk("fs_period_1", fs_pos[1], FT);
            chk("fs_period_2", fs_pos[2], 2 * FT);
        end
        chk("bl_rise_at_2nd_wrap", bl_rise, 2 * FT - 1);

        // Disable mid-frame in ON: backlight drops next clock, frame drains
        for (int k = 0; k < 51; k++) @(negedge clk_in);
        chk("on_bl", lcd_bl, 1);
        enable = 1'b0;
        @(negedge clk_in);
        chk("drain_bl_drop", lcd_bl, 0);
        fs_at = -1;
        for (int t = 3 * FT + 52; t <= 5 * FT; t++) begin
            @(negedge clk_in);
            if (t == 4 * FT - HT) chk("drain_hs_runs", lcd_hs, 1);
            if (t == 4 * FT) begin
                chk("off_hs", lcd_hs, 0);
                chk("off_vs", lcd_vs, 0);
                chk("off_px", pix_x, 10'h3FF);
                chk("off_bl", lcd_bl, 0);
            end
            if (frame_start) begin
                fs_at = t;
                break;
            end
            // Re-enable during the drain; must not cut the drain short
            if (t == 3 * FT + 60) enable = 1'b1;
        end
        chk("drain_then_restart_fs", fs_at, 4 * FT + 1);

        // Run up to an active DE beat in ON, then pull reset between clock edges
        for (int k = 1; k <= 2 * FT + 81; k++) @(negedge clk_in);
        chk("pre_rst_bl", lcd_bl, 1);
        chk("pre_rst_de", lcd_de, 1);
        chk("pre_rst_px", pix_x, 10'd7);
        chk("pre_rst_rgb", lcd_rgb, 24'h018000);
        mon_en = 1'b0;
        #2 sys_rst_n = 1'b0;
        #1;
        chk("async_rst_px", pix_x, 10'h3FF);
        chk("async_rst_py", pix_y, 10'h3FF);
        chk("async_rst_de", lcd_de, 0);
        chk("async_rst_bl", lcd_bl, 0);
        chk("async_rst_rgb", lcd_rgb, 0);
        repeat (2) @(negedge clk_in);
        sys_rst_n = 1'b1;
        wait_fs(lat);
        chk("post_rst_restart", lat, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
